xg_block_sync: RTL and testbench
================================

Name: xg_block_sync

Overview:
- 10GBASE-R 64b/66b block-synchronisation stage, in the same spirit as IEEE 802.3 clause 49.
- Sits between the GTX RX gearbox outputs (header, header-valid) and the XGMAC PCS receive logic, in the xg0 RX clock domain.
- Hunts for alignment by pulsing the gearbox slip input, declares block lock, and monitors header errors to drop lock.
- Also provides a saturating header-error counter for the performance counters.

Parameters:
- LOCK_COUNT, 64: consecutive valid sync headers required to declare lock.
- WINDOW, 1024: headers per error-monitoring window while locked.
- MAX_INVALID, 16: invalid headers within one window that cause loss of lock.
- SLIP_WAIT, 32: rx_clk cycles after each slip during which headers are ignored (gearbox settling).

Ports:
- rx_clk, input, 1: recovered RX user clock; sole clock.
- rst_n, input, 1: synchronous, active-low reset.
- rx_header_valid, input, 1: gearbox header qualifier.
- rx_header, input, 2: 66b sync header; 2'b01 and 2'b10 are valid, 2'b00 and 2'b11 are invalid.
- sfp_los, input, 1: SFP loss of signal; asynchronous, synchronised internally.
- err_count_clear, input, 1: clears header_err_count.
- rx_bitslip, output, 1: one-cycle slip pulse to the gearbox.
- block_lock, output, 1: block lock achieved.
- lock_lost, output, 1: one-cycle pulse when lock drops.
- header_err_count, output, 16: saturating count of invalid headers.

Behaviour:
- Reset (rst_n=0 at a rx_clk edge):
  - State goes to HUNT and all internal counters clear.
  - rx_bitslip=0, block_lock=0, lock_lost=0, header_err_count=0.
  - Reset asserted mid-operation (including during SLIP_WAIT) aborts immediately, with no pending pulse.
- sfp_los synchroniser: 2-flop synchroniser, so internal los_sync lags the pin by 2 cycles.
- All outputs are registered. A header sampled on cycle N affects outputs on cycle N+1.
- A header is "sampled" only when rx_header_valid=1.
- HUNT:
  - Valid header: good_cnt increments.
  - If good_cnt==LOCK_COUNT-1 and the header is valid: go to LOCKED, block_lock=1, clear the window counters.
  - Invalid header: rx_bitslip=1 for exactly one cycle, good_cnt=0, load wait_cnt=SLIP_WAIT-1, go to SLIP_WAIT.
- SLIP_WAIT:
  - rx_header and rx_header_valid are ignored; headers are not counted in header_err_count.
  - wait_cnt decrements each cycle; at 0, go to HUNT.
  - Back-to-back slips are therefore spaced SLIP_WAIT+1 cycles apart (first slip to next possible slip).
- LOCKED:
  - Every sampled header increments win_cnt; invalid headers also increment bad_cnt.
  - If the sampled header is invalid and bad_cnt==MAX_INVALID-1:
    - block_lock=0, rx_bitslip=1, lock_lost=1 (each for one cycle where a pulse), clear counters, go to SLIP_WAIT.
  - Otherwise, if win_cnt==WINDOW-1: clear win_cnt and bad_cnt. The header on the boundary belongs to the closing window.
  - If the MAX_INVALID-th invalid header lands on the WINDOW-th header, loss of lock wins.
- sfp_los (synchronised) high, in any state and with priority over all header events:
  - Go to HUNT, clear good_cnt, win_cnt, bad_cnt and wait_cnt; block_lock=0; no rx_bitslip.
  - lock_lost=1 for one cycle only if block_lock was 1.
  - The block stays in HUNT with counters held at 0 while los_sync=1.
- header_err_count:
  - Increments on each invalid header sampled in HUNT or LOCKED.
  - Saturates at 16'hFFFF.
  - err_count_clear alone gives 0 next cycle.
  - Clear coincident with an increment gives 1, so no error is lost.
- Counter widths are sized by $clog2 of their parameter, with no wrap-around in normal operation.

Test Plan:
1. rst_n released, 64 valid headers (2'b01), valid every other cycle -> block_lock=1 one cycle after the 64th; rx_bitslip never asserted; header_err_count=0.
2. In HUNT after 10 valid headers, send one 2'b11 -> rx_bitslip high for exactly 1 cycle; next 32 cycles of headers (including 2'b00) ignored; header_err_count=1; 64 valid headers after that -> lock.
3. Locked, 15 invalid headers spread over a 1024-header window, then the window rolls over, then 15 more -> block_lock stays 1; header_err_count=30.
4. Locked, 16th invalid header placed on the 1024th header of the window -> block_lock=0, lock_lost=1 and rx_bitslip=1 on the same cycle; state SLIP_WAIT.
5. Locked, sfp_los pulsed high for 5 cycles -> block_lock=0 and lock_lost=1 pulse 3 cycles after the pin edge, no rx_bitslip; relock requires a full 64 valid headers after los_sync falls.
6. Force header_err_count to 16'hFFFF via invalid headers -> holds at FFFF; err_count_clear on the same cycle as an invalid header -> 1; clear alone -> 0. Apply rst_n=0 during SLIP_WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/xg_block_sync.sv
//==============================================================================
// xg_block_sync : 64b/66b block lock (slip hunt, lock, header-error monitor)
// Rev 1.0 : initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module xg_block_sync #(
  parameter int LOCK_COUNT  = 64,
  parameter int WINDOW      = 1024,
  parameter int MAX_INVALID = 16,
  parameter int SLIP_WAIT   = 32
) (
  input  logic        rx_clk,
  input  logic        rst_n,
  input  logic        rx_header_valid,
  input  logic [1:0]  rx_header,
  input  logic        sfp_los,
  input  logic        err_count_clear,
  output logic        rx_bitslip,
  output logic        block_lock,
  output logic        lock_lost,
  output logic [15:0] header_err_count
);

  localparam int c_GW = (LOCK_COUNT  > 1) ? $clog2(LOCK_COUNT)  : 1;
  localparam int c_WW = (WINDOW      > 1) ? $clog2(WINDOW)      : 1;
  localparam int c_BW = (MAX_INVALID > 1) ? $clog2(MAX_INVALID) : 1;
  localparam int c_TW = (SLIP_WAIT   > 1) ? $clog2(SLIP_WAIT)   : 1;

  localparam logic [c_GW-1:0] c_GOOD_LAST = c_GW'(LOCK_COUNT - 1);
  localparam logic [c_WW-1:0] c_WIN_LAST  = c_WW'(WINDOW - 1);
  localparam logic [c_BW-1:0] c_BAD_LAST  = c_BW'(MAX_INVALID - 1);
  localparam logic [c_TW-1:0] c_WAIT_LOAD = c_TW'(SLIP_WAIT - 1);

  localparam logic [1:0] c_ST_HUNT = 2'd0;
  localparam logic [1:0] c_ST_SLIP = 2'd1;
  localparam logic [1:0] c_ST_LOCK = 2'd2;

  logic [1:0]      r_state;
  logic [c_GW-1:0] r_good_cnt;
  logic [c_WW-1:0] r_win_cnt;
  logic [c_BW-1:0] r_bad_cnt;
  logic [c_TW-1:0] r_wait_cnt;
  logic            r_los_meta;
  logic            r_los_sync;
  logic            r_bitslip;
  logic            r_block_lock;
  logic            r_lock_lost;
  logic [15:0]     r_err_cnt;

  logic w_hdr_good;
  logic w_hdr_bad;
  logic w_err_inc;

  // 01/10 are the only legal sync headers: exactly one bit set
  assign w_hdr_good = rx_header_valid &&  (rx_header[1] ^ rx_header[0]);
  assign w_hdr_bad  = rx_header_valid && !(rx_header[1] ^ rx_header[0]);
  assign w_err_inc  = w_hdr_bad && !r_los_sync && (r_state != c_ST_SLIP);

  always_ff @(posedge rx_clk) begin
    if (!rst_n) begin
      r_los_meta <= 1'b0;
      r_los_sync <= 1'b0;
    end else begin
      r_los_meta <= sfp_los;
      r_los_sync <= r_los_meta;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (!rst_n) begin
      r_state      <= c_ST_HUNT;
      r_good_cnt   <= '0;
      r_win_cnt    <= '0;
      r_bad_cnt    <= '0;
      r_wait_cnt   <= '0;
      r_bitslip    <= 1'b0;
      r_block_lock <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      r_bitslip   <= 1'b0;
      r_lock_lost <= 1'b0;
      if (r_los_sync) begin
        // LOS overrides every header event and parks the hunt at zero
        r_state      <= c_ST_HUNT;
        r_good_cnt   <= '0;
        r_win_cnt    <= '0;
        r_bad_cnt    <= '0;
        r_wait_cnt   <= '0;
        r_block_lock <= 1'b0;
        r_lock_lost  <= r_block_lock;
      end else begin
        case (r_state)
          c_ST_HUNT: begin
            if (w_hdr_bad) begin
              r_bitslip  <= 1'b1;
              r_good_cnt <= '0;
              r_wait_cnt <= c_WAIT_LOAD;
              r_state    <= c_ST_SLIP;
            end else if (w_hdr_good) begin
              if (r_good_cnt == c_GOOD_LAST) begin
                r_good_cnt   <= '0;
                r_win_cnt    <= '0;
                r_bad_cnt    <= '0;
                r_block_lock <= 1'b1;
                r_state      <= c_ST_LOCK;
              end else begin
                r_good_cnt <= r_good_cnt + c_GW'(1);
              end
            end
          end
          c_ST_SLIP: begin
            if (r_wait_cnt == '0) begin
              r_state <= c_ST_HUNT;
            end else begin
              r_wait_cnt <= r_wait_cnt - c_TW'(1);
            end
          end
          c_ST_LOCK: begin
            if (rx_header_valid) begin
              // loss of lock takes precedence over the window boundary
              if (w_hdr_bad && (r_bad_cnt == c_BAD_LAST)) begin
                r_block_lock <= 1'b0;
                r_bitslip    <= 1'b1;
                r_lock_lost  <= 1'b1;
                r_win_cnt    <= '0;
                r_bad_cnt    <= '0;
                r_good_cnt   <= '0;
                r_wait_cnt   <= c_WAIT_LOAD;
                r_state      <= c_ST_SLIP;
              end else if (r_win_cnt == c_WIN_LAST) begin
                r_win_cnt <= '0;
                r_bad_cnt <= '0;
              end else begin
                r_win_cnt <= r_win_cnt + c_WW'(1);
                if (w_hdr_bad) begin
                  r_bad_cnt <= r_bad_cnt + c_BW'(1);
                end
              end
            end
          end
          default: begin
            r_state <= c_ST_HUNT;
          end
        endcase
      end
    end
  end

  // A clear that coincides with an error restarts at 1 so the error is kept
  always_ff @(posedge rx_clk) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (err_count_clear) begin
      r_err_cnt <= w_err_inc ? 16'd1 : 16'd0;
    end else if (w_err_inc && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign rx_bitslip       = r_bitslip;
  assign block_lock       = r_block_lock;
  assign lock_lost        = r_lock_lost;
  assign header_err_count = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_xg_block_sync.sv
//==============================================================================
// tb_xg_block_sync : vector table, directed sequences and random vs. model
// Rev 1.0 : initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_xg_block_sync;

  localparam int LOCK_COUNT  = 64;
  localparam int WINDOW      = 1024;
  localparam int MAX_INVALID = 16;
  localparam int SLIP_WAIT   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, hv, los, clr;
  logic [1:0]  hdr;
  logic        slip, lock, lost;
  logic [15:0] err;

  logic        rst2_n, hv2, los2, clr2;
  logic [1:0]  hdr2;
  logic        slip2, lock2, lost2;
  logic [15:0] err2;

  xg_block_sync #(
    .LOCK_COUNT(LOCK_COUNT), .WINDOW(WINDOW),
    .MAX_INVALID(MAX_INVALID), .SLIP_WAIT(SLIP_WAIT)
  ) u_dut (
    .rx_clk(clk), .rst_n(rst_n), .rx_header_valid(hv), .rx_header(hdr),
    .sfp_los(los), .err_count_clear(clr), .rx_bitslip(slip),
    .block_lock(lock), .lock_lost(lost), .header_err_count(err)
  );

  // Small window with an unreachable invalid limit: every bad header counts
  xg_block_sync #(
    .LOCK_COUNT(4), .WINDOW(4), .MAX_INVALID(8), .SLIP_WAIT(4)
  ) u_dut_sat (
    .rx_clk(clk), .rst_n(rst2_n), .rx_header_valid(hv2), .rx_header(hdr2),
    .sfp_los(los2), .err_count_clear(clr2), .rx_bitslip(slip2),
    .block_lock(lock2), .lock_lost(lost2), .header_err_count(err2)
  );

  int n_pass  = 0;
  int n_total = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  // Reference model: hunt run-length, window tallies, slip quiet period by time stamp
  int m_lock, m_slip, m_lost, m_err;
  int m_run, m_wn, m_wb, m_slipping, m_slip_cyc, m_cyc;
  bit m_pipe0, m_pipe1;

  function automatic void model_step(input bit r, input bit v, input bit [1:0] h,
                                     input bit p, input bit c);
    int bad, quiet, inc;
    bit le;
    m_cyc++;
    m_slip = 0;
    m_lost = 0;
    if (!r) begin
      m_lock = 0; m_err = 0; m_run = 0; m_wn = 0; m_wb = 0; m_slipping = 0;
      m_pipe0 = 0; m_pipe1 = 0;
      return;
    end
    le = m_pipe1;
    m_pipe1 = m_pipe0;
    m_pipe0 = p;
    bad   = (v && (h == 2'b00 || h == 2'b11)) ? 1 : 0;
    quiet = (m_slipping != 0 && (m_cyc - m_slip_cyc) <= SLIP_WAIT) ? 1 : 0;
    inc   = (bad != 0 && !le && quiet == 0) ? 1 : 0;
    if (le) begin
      m_lost = m_lock; m_lock = 0; m_run = 0; m_wn = 0; m_wb = 0; m_slipping = 0;
    end else if (quiet == 0) begin
      m_slipping = 0;
      if (m_lock == 0) begin
        if (bad != 0) begin
          m_slip = 1; m_run = 0; m_slipping = 1; m_slip_cyc = m_cyc;
        end else if (v) begin
          m_run++;
          if (m_run == LOCK_COUNT) begin
            m_lock = 1; m_run = 0; m_wn = 0; m_wb = 0;
          end
        end
      end else if (v) begin
        m_wn++;
        m_wb += bad;
        if (m_wb == MAX_INVALID) begin
          m_lock = 0; m_lost = 1; m_slip = 1; m_slipping = 1; m_slip_cyc = m_cyc;
          m_wn = 0; m_wb = 0;
        end else if (m_wn == WINDOW) begin
          m_wn = 0; m_wb = 0;
        end
      end
    end
    if (c) m_err = inc;
    else if (inc != 0 && m_err < 65535) m_err++;
  endfunction

  task automatic drive(input bit r, input bit v, input bit [1:0] h, input bit c);
    rst_n = r; hv = v; hdr = h; clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst_n, hv, hdr, los, clr);
    #1;
    check("model_slip", int'(slip), m_slip);
    check("model_lock", int'(lock), m_lock);
    check("model_lost", int'(lost), m_lost);
    check("model_err",  int'(err),  m_err);
  endtask

  task automatic tick2();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 2'b00, 0);
    tick();
    drive(1, 0, 2'b00, 0);
  endtask

  typedef struct {
    bit       r;
    bit       v;
    bit [1:0] h;
    bit       c;
    bit       e_slip;
    bit       e_lock;
    bit       e_lost;
    int       e_err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    m_lock = 0; m_slip = 0; m_lost = 0; m_err = 0; m_run = 0; m_wn = 0; m_wb = 0;
    m_slipping = 0; m_slip_cyc = 0; m_cyc = 0; m_pipe0 = 0; m_pipe1 = 0;
    rst_n = 0; hv = 0; hdr = 2'b00; los = 0; clr = 0;
    rst2_n = 0; hv2 = 0; hdr2 = 2'b00; los2 = 0; clr2 = 0;

    tbl[0] = '{0, 0, 2'b00, 0, 0, 0, 0, 0};  // reset
    tbl[1] = '{1, 1, 2'b01, 0, 0, 0, 0, 0};  // good header in hunt
    tbl[2] = '{1, 1, 2'b11, 0, 1, 0, 0, 1};  // bad header -> slip
    tbl[3] = '{1, 1, 2'b00, 0, 0, 0, 0, 1};  // ignored in slip wait
    tbl[4] = '{1, 1, 2'b11, 0, 0, 0, 0, 1};  // ignored in slip wait
    tbl[5] = '{0, 1, 2'b11, 0, 0, 0, 0, 0};  // reset during slip wait
    tbl[6] = '{1, 1, 2'b10, 0, 0, 0, 0, 0};  // good header
    tbl[7] = '{1, 1, 2'b00, 1, 1, 0, 0, 1};  // clear coincident with error
    tbl[8] = '{1, 0, 2'b00, 1, 0, 0, 0, 0};  // clear alone
    tbl[9] = '{1, 1, 2'b11, 0, 0, 0, 0, 0};  // still in slip wait

    fork
      begin : main_seq
        int bad_seen;
        for (int i = 0; i < 10; i++) begin
          drive(tbl[i].r, tbl[i].v, tbl[i].h, tbl[i].c);
          tick();
          check($sformatf("tbl%0d_slip", i), int'(slip), int'(tbl[i].e_slip));
          check($sformatf("tbl%0d_lock", i), int'(lock), int'(tbl[i].e_lock));
          check($sformatf("tbl%0d_lost", i), int'(lost), int'(tbl[i].e_lost));
          check($sformatf("tbl%0d_err",  i), int'(err),  tbl[i].e_err);
        end

        // Lock after 64 good headers presented every other cycle
        do_reset();
        for (int i = 0; i < 64; i++) begin
          drive(1, 1, 2'b01, 0);
          tick();
          check("t1_lock", int'(lock), (i == 63) ? 1 : 0);
          check("t1_slip", int'(slip), 0);
          drive(1, 0, 2'b01, 0);
          tick();
          check("t1_lock_gap", int'(lock), (i == 63) ? 1 : 0);
        end
        check("t1_err", int'(err), 0);

        // One bad header mid-hunt, quiet period, then relock
        do_reset();
        for (int i = 0; i < 10; i++) begin
          drive(1, 1, 2'b10, 0);
          tick();
        end
        drive(1, 1, 2'b11, 0);
        tick();
        check("t2_slip", int'(slip), 1);
        check("t2_err", int'(err), 1);
        for (int i = 0; i < SLIP_WAIT; i++) begin
          drive(1, 1, (i % 2 == 1) ? 2'b00 : 2'b11, 0);
          tick();
          check("t2_quiet_slip", int'(slip), 0);
          check("t2_quiet_err", int'(err), 1);
        end
        for (int i = 0; i < 64; i++) begin
          drive(1, 1, (i % 2 == 1) ? 2'b10 : 2'b01, 0);
          tick();
          check("t2_lock", int'(lock), (i == 63) ? 1 : 0);
        end

        // Two windows of 15 errors each keep lock
        drive(1, 0, 2'b00, 1);
        tick();
        check("t3_clr", int'(err), 0);
        for (int w = 0; w < 2; w++) begin
          bad_seen = 0;
          for (int i = 0; i < WINDOW; i++) begin
            drive(1, 1, ((i % 64 == 5) && (i / 64 < 15)) ? 2'b11 : 2'b01, 0);
            tick();
            if (!lock) bad_seen = 1;
          end
          check("t3_lock_held", bad_seen, 0);
        end
        check("t3_err", int'(err), 30);

        // 16th error on the window boundary drops lock
        for (int i = 0; i < WINDOW; i++) begin
          drive(1, 1, (((i % 64 == 5) && (i / 64 < 15)) || i == WINDOW - 1) ? 2'b00 : 2'b10, 0);
          tick();
          if (i == WINDOW - 1) begin
            check("t4_lock", int'(lock), 0);
            check("t4_lost", int'(lost), 1);
            check("t4_slip", int'(slip), 1);
          end else if (i == WINDOW - 2) begin
            check("t4_lock_pre", int'(lock), 1);
          end
        end
        for (int i = 0; i < SLIP_WAIT; i++) begin
          drive(1, 1, 2'b11, 0);
          tick();
          check("t4_quiet_slip", int'(slip), 0);
          check("t4_quiet_lost", int'(lost), 0);
        end
        check("t4_err", int'(err), 46);
        drive(1, 1, 2'b11, 0);
        tick();
        check("t4_reslip", int'(slip), 1);
        check("t4_err_inc", int'(err), 47);

        // LOS pulse while locked
        for (int i = 0; i < SLIP_WAIT; i++) begin
          drive(1, 0, 2'b00, 0);
          tick();
        end
        for (int i = 0; i < 64; i++) begin
          drive(1, 1, 2'b01, 0);
          tick();
        end
        check("t5_locked", int'(lock), 1);
        los = 1'b1;
        for (int t = 1; t <= 7; t++) begin
          if (t == 6) los = 1'b0;
          tick();
          check("t5_lock", int'(lock), (t < 3) ? 1 : 0);
          check("t5_lost", int'(lost), (t == 3) ? 1 : 0);
          check("t5_slip", int'(slip), 0);
        end
        for (int i = 0; i < 64; i++) begin
          tick();
          check("t5_relock", int'(lock), (i == 63) ? 1 : 0);
        end

        // Randomised traffic against the model, three error densities
        do_reset();
        for (int ph = 0; ph < 3; ph++) begin
          int den;
          den = (ph == 0) ? 128 : ((ph == 1) ? 40 : 4);
          for (int n = 0; n < 4000; n++) begin
            bit b, rr, vv, cc;
            bit [1:0] hh;
            rr = ($urandom_range(0, 999) != 0);
            vv = ($urandom_range(0, 3) != 0);
            cc = ($urandom_range(0, 199) == 0);
            b  = ($urandom_range(0, den - 1) == 0);
            hh = b ? ($urandom_range(0, 1) ? 2'b11 : 2'b00)
                   : ($urandom_range(0, 1) ? 2'b10 : 2'b01);
            drive(rr, vv, hh, cc);
            tick();
          end
        end
      end

      begin : sat_seq
        tick2();
        check("sat_rst_err", int'(err2), 0);
        check("sat_rst_lock", int'(lock2), 0);
        rst2_n = 1; hv2 = 1; hdr2 = 2'b01;
        repeat (4) tick2();
        check("sat_lock", int'(lock2), 1);
        hdr2 = 2'b11;
        for (int i = 0; i < 65534; i++) tick2();
        check("sat_fffe", int'(err2), 16'hFFFE);
        tick2();
        check("sat_ffff", int'(err2), 16'hFFFF);
        repeat (5) tick2();
        check("sat_hold", int'(err2), 16'hFFFF);
        check("sat_lock_held", int'(lock2), 1);
        check("sat_no_slip", int'(slip2), 0);
        check("sat_no_lost", int'(lost2), 0);
        clr2 = 1;
        tick2();
        check("sat_clr_inc", int'(err2), 1);
        hv2 = 0;
        tick2();
        check("sat_clr_alone", int'(err2), 0);
        clr2 = 0;
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
